// File: rtl/muldiv_hilo_ctrl.sv
// HI/LO register owner for the integer multiply/divide unit.
// Sequences MULT/MULTU through a fixed-latency multiply and DIV/DIVU through a
// radix-2 restoring divider. It also performs MTHI/MTLO writes, and stalls decode
// MFHI/MFLO while a multi-cycle operation is in flight.
`timescale 1ns/1ps
module muldiv_hilo_ctrl #(
  parameter int MUL_LAT  = 3,   // accept edge to HI/LO update edge, 1..8
  parameter int DIV_ITER = 32   // one quotient bit per iteration
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic [2:0]  req_op,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  output logic        req_ready,
  input  logic        flush,
  input  logic        rd_hilo,
  output logic        rd_stall,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int CNT_W = 6;

  typedef enum logic [1:0] {ST_IDLE, ST_MUL, ST_DIV, ST_DFIX} state_t;

  state_t            state_reg, state_next;
  logic [CNT_W-1:0]  cnt_reg;
  logic [31:0]       hi_reg, lo_reg;
  logic [31:0]       mul_a_reg, mul_b_reg;
  logic              mul_signed_reg;
  logic [31:0]       rem_reg, quo_reg, dvs_reg;
  logic              qsign_reg, rsign_reg;

  logic              accept;
  logic              is_mul, is_div, div_signed;
  logic              a_neg, b_neg;
  logic [31:0]       a_mag, b_mag;
  logic [31:0]       mul_a_src, mul_b_src;
  logic              mul_signed_src;
  logic [63:0]       mul_a_ext, mul_b_ext, product;
  logic [32:0]       div_shift, div_trial;
  logic [31:0]       quo_fix, rem_fix;

  // With a single-cycle multiply the product is taken straight from the request;
  // otherwise it comes from the operands latched at accept.
  generate
    if (MUL_LAT == 1) begin : g_mul_direct
      assign mul_a_src      = req_a;
      assign mul_b_src      = req_b;
      assign mul_signed_src = (req_op == 3'd0);
    end else begin : g_mul_latched
      assign mul_a_src      = mul_a_reg;
      assign mul_b_src      = mul_b_reg;
      assign mul_signed_src = mul_signed_reg;
    end
  endgenerate

  // Request decode, operand conditioning, the product, and one divider step.
  always_comb begin
    accept     = req_valid & req_ready & ~flush;
    is_mul     = (req_op == 3'd0) || (req_op == 3'd1);
    is_div     = (req_op == 3'd2) || (req_op == 3'd3);
    div_signed = (req_op == 3'd2);
    a_neg      = div_signed & req_a[31];
    b_neg      = div_signed & req_b[31];
    a_mag      = a_neg ? -req_a : req_a;
    b_mag      = b_neg ? -req_b : req_b;
    mul_a_ext  = mul_signed_src ? {{32{mul_a_src[31]}}, mul_a_src} : {32'd0, mul_a_src};
    mul_b_ext  = mul_signed_src ? {{32{mul_b_src[31]}}, mul_b_src} : {32'd0, mul_b_src};
    product    = mul_a_ext * mul_b_ext;
    div_shift  = {rem_reg, quo_reg[31]};
    div_trial  = div_shift - {1'b0, dvs_reg};
    quo_fix    = qsign_reg ? -quo_reg : quo_reg;
    rem_fix    = rsign_reg ? -rem_reg : rem_reg;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_reg <= ST_IDLE;
    else       state_reg <= state_next;
  end

  // Next-state logic; flush returns to IDLE from anywhere.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: begin
        if (accept) begin
          if (is_mul && (MUL_LAT > 1))        state_next = ST_MUL;
          else if (is_div && (req_b != 32'd0)) state_next = ST_DIV;
        end
      end
      ST_MUL:  if (flush || cnt_reg == '0) state_next = ST_IDLE;
      ST_DIV: begin
        if (flush)                                  state_next = ST_IDLE;
        else if (cnt_reg == CNT_W'(DIV_ITER - 1))   state_next = ST_DFIX;
      end
      ST_DFIX: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Handshake and stall outputs.
  always_comb begin
    req_ready = (state_reg == ST_IDLE);
    busy      = (state_reg != ST_IDLE);
    rd_stall  = rd_hilo & busy;
    hi        = hi_reg;
    lo        = lo_reg;
  end

  // Datapath: HI/LO writes, operand capture, counter and divider iteration.
  always_ff @(posedge clk) begin
    if (reset) begin
      hi_reg         <= '0;
      lo_reg         <= '0;
      cnt_reg        <= '0;
      mul_a_reg      <= '0;
      mul_b_reg      <= '0;
      mul_signed_reg <= 1'b0;
      rem_reg        <= '0;
      quo_reg        <= '0;
      dvs_reg        <= '0;
      qsign_reg      <= 1'b0;
      rsign_reg      <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (accept) begin
            if (req_op == 3'd4) hi_reg <= req_a;
            if (req_op == 3'd5) lo_reg <= req_a;
            if (is_mul) begin
              if (MUL_LAT == 1) begin
                {hi_reg, lo_reg} <= product;
              end else begin
                mul_a_reg      <= req_a;
                mul_b_reg      <= req_b;
                mul_signed_reg <= (req_op == 3'd0);
                cnt_reg        <= CNT_W'(MUL_LAT - 1);
              end
            end
            // A zero divisor leaves HI/LO untouched and never leaves IDLE.
            if (is_div && (req_b != 32'd0)) begin
              rem_reg   <= '0;
              quo_reg   <= a_mag;
              dvs_reg   <= b_mag;
              qsign_reg <= a_neg ^ b_neg;
              rsign_reg <= a_neg;
              cnt_reg   <= '0;
            end
          end
        end
        ST_MUL: begin
          if (!flush) begin
            cnt_reg <= cnt_reg - CNT_W'(1);
            if (cnt_reg == '0) {hi_reg, lo_reg} <= product;
          end
        end
        ST_DIV: begin
          if (!flush) begin
            cnt_reg <= cnt_reg + CNT_W'(1);
            if (!div_trial[32]) begin
              rem_reg <= div_trial[31:0];
              quo_reg <= {quo_reg[30:0], 1'b1};
            end else begin
              rem_reg <= div_shift[31:0];
              quo_reg <= {quo_reg[30:0], 1'b0};
            end
          end
        end
        ST_DFIX: begin
          if (!flush) begin
            lo_reg <= quo_fix;
            hi_reg <= rem_fix;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_hilo_ctrl.sv
// Directed bench for muldiv_hilo_ctrl: MTHI/MTLO, MULT/MULTU latency and stall,
// signed/unsigned divide including the wrap case, divide by zero, flush and reset aborts.
`timescale 1ns/1ps
module tb_muldiv_hilo_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic [2:0]  req_op;
  logic [31:0] req_a, req_b;
  logic        req_ready;
  logic        flush;
  logic        rd_hilo;
  logic        rd_stall;
  logic        busy;
  logic [31:0] hi, lo;

  int checks = 0;
  int errors = 0;
  int n;

  always #5 clk = ~clk;

  muldiv_hilo_ctrl #(.MUL_LAT(3), .DIV_ITER(32)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_op(req_op),
    .req_a(req_a), .req_b(req_b), .req_ready(req_ready), .flush(flush),
    .rd_hilo(rd_hilo), .rd_stall(rd_stall), .busy(busy), .hi(hi), .lo(lo)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one operation for a single cycle (accepted at that edge when idle).
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    req_valid = 1'b1;
    req_op    = op;
    req_a     = a;
    req_b     = b;
    tick();
    req_valid = 1'b0;
  endtask

  // Count cycles until busy drops, bounded.
  task automatic wait_idle(output int cycles);
    cycles = 0;
    while (busy === 1'b1 && cycles < 200) begin
      tick();
      cycles++;
    end
  endtask

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_op = 3'd0; req_a = '0; req_b = '0;
    flush = 1'b0; rd_hilo = 1'b1;
    tick(); tick();
    check("reset_hi", hi, 32'h0);
    check("reset_lo", lo, 32'h0);
    check("reset_busy", busy, 32'h0);
    check("reset_ready", req_ready, 32'h1);
    check("reset_rd_stall", rd_stall, 32'h0);
    reset = 1'b0;

    // MTHI then MTLO on consecutive cycles
    issue(3'd4, 32'h12345678, 32'h0);
    check("mthi_hi", hi, 32'h12345678);
    check("mthi_busy", busy, 32'h0);
    issue(3'd5, 32'h9ABCDEF0, 32'h0);
    check("mtlo_lo", lo, 32'h9ABCDEF0);
    check("mtlo_hi", hi, 32'h12345678);
    check("mtlo_busy", busy, 32'h0);
    $display("MTHI/MTLO  hi=%h lo=%h", hi, lo);

    // MULT -2 * 3 with MFHI held in decode: 3 stall cycles
    issue(3'd0, 32'hFFFFFFFE, 32'h00000003);
    for (int i = 0; i < 3; i++) begin
      check("mult_stall", rd_stall, 32'h1);
      check("mult_hi_hold", hi, 32'h12345678);
      tick();
    end
    check("mult_stall_done", rd_stall, 32'h0);
    check("mult_hi", hi, 32'hFFFFFFFF);
    check("mult_lo", lo, 32'hFFFFFFFA);
    $display("MULT       hi=%h lo=%h", hi, lo);

    issue(3'd1, 32'hFFFFFFFE, 32'h00000003);
    wait_idle(n);
    check("multu_latency", n, 32'd3);
    check("multu_hi", hi, 32'h00000002);
    check("multu_lo", lo, 32'hFFFFFFFA);
    $display("MULTU      hi=%h lo=%h", hi, lo);

    // Signed and unsigned divides
    issue(3'd2, 32'hFFFFFFF9, 32'h00000002);
    wait_idle(n);
    check("div_latency", n, 32'd33);
    check("div_lo", lo, 32'hFFFFFFFD);
    check("div_hi", hi, 32'hFFFFFFFF);
    $display("DIV -7/2   hi=%h lo=%h", hi, lo);

    issue(3'd3, 32'd100, 32'd7);
    wait_idle(n);
    check("divu_latency", n, 32'd33);
    check("divu_lo", lo, 32'd14);
    check("divu_hi", hi, 32'd2);
    $display("DIVU 100/7 hi=%h lo=%h", hi, lo);

    issue(3'd2, 32'h80000000, 32'hFFFFFFFF);
    wait_idle(n);
    check("divwrap_lo", lo, 32'h80000000);
    check("divwrap_hi", hi, 32'h00000000);
    $display("DIV wrap   hi=%h lo=%h", hi, lo);

    // Divide by zero is a no-op
    issue(3'd4, 32'd5, 32'h0);
    issue(3'd5, 32'd6, 32'h0);
    issue(3'd3, 32'd100, 32'd0);
    check("div0_busy", busy, 32'h0);
    check("div0_ready", req_ready, 32'h1);
    tick();
    check("div0_busy2", busy, 32'h0);
    check("div0_hi", hi, 32'd5);
    check("div0_lo", lo, 32'd6);
    $display("DIVU /0    hi=%h lo=%h", hi, lo);

    // Flush 10 cycles into a divide
    issue(3'd3, 32'd100, 32'd7);
    for (int i = 0; i < 9; i++) tick();
    check("flush10_busy_before", busy, 32'h1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush10_busy", busy, 32'h0);
    check("flush10_ready", req_ready, 32'h1);
    check("flush10_hi", hi, 32'd5);
    check("flush10_lo", lo, 32'd6);
    $display("DIV flush@10 hi=%h lo=%h", hi, lo);

    // Flush exactly on the sign-fix cycle
    issue(3'd3, 32'd100, 32'd7);
    for (int i = 0; i < 32; i++) tick();
    check("flushfix_busy_before", busy, 32'h1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flushfix_busy", busy, 32'h0);
    check("flushfix_hi", hi, 32'd5);
    check("flushfix_lo", lo, 32'd6);
    $display("DIV flush@fix hi=%h lo=%h", hi, lo);

    // Flush on the multiply completion cycle
    issue(3'd1, 32'd9, 32'd9);
    tick(); tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flushmul_busy", busy, 32'h0);
    check("flushmul_lo", lo, 32'd6);
    $display("MULTU flush hi=%h lo=%h", hi, lo);

    // MTHI offered with flush is dropped
    flush = 1'b1;
    issue(3'd4, 32'hDEADBEEF, 32'h0);
    flush = 1'b0;
    check("mthi_flush_hi", hi, 32'd5);
    $display("MTHI flush hi=%h lo=%h", hi, lo);

    // Reset one cycle into a multiply
    issue(3'd0, 32'd7, 32'd7);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rstmul_hi", hi, 32'h0);
    check("rstmul_lo", lo, 32'h0);
    check("rstmul_busy", busy, 32'h0);
    $display("MULT reset hi=%h lo=%h", hi, lo);

    // Request held during a divide is accepted only after completion
    req_valid = 1'b1; req_op = 3'd3; req_a = 32'd100; req_b = 32'd7;
    tick();
    req_op = 3'd4; req_a = 32'hCAFEBABE;
    n = 0;
    while (busy === 1'b1 && n < 200) begin
      check("held_ignored_hi", hi, 32'h0);
      tick();
      n++;
    end
    check("held_div_latency", n, 32'd33);
    check("held_div_hi", hi, 32'd2);
    check("held_div_lo", lo, 32'd14);
    check("held_ready", req_ready, 32'h1);
    tick();
    req_valid = 1'b0;
    check("held_mthi_hi", hi, 32'hCAFEBABE);
    check("held_mthi_lo", lo, 32'd14);
    $display("HELD MTHI  hi=%h lo=%h", hi, lo);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/muldiv_hilo_ctrl.md
Name: muldiv_hilo_ctrl

Overview:
- Owns the architectural HI/LO registers and sequences every HI/LO write.
- Handles MULT, MULTU, DIV, DIVU, MTHI and MTLO issued from execute.
- Decode reads HI/LO from this block for MFHI/MFLO and receives a stall request while a multi-cycle operation is in flight.
- Contains a fixed-latency multiply pipeline and a radix-2 iterative restoring divider.

Parameters:
- MUL_LAT, 3, cycles from accept edge to the HI/LO update edge for MULT/MULTU; legal range 1..8.
- DIV_ITER, 32, divider iteration count; fixed at 32 for the 32-bit datapath.

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- req_valid  input  1  execute presents an operation.
- req_op  input  3  0=MULT, 1=MULTU, 2=DIV, 3=DIVU, 4=MTHI, 5=MTLO; 6 and 7 are ignored (accepted, no effect).
- req_a  input  32  rs value (dividend / multiplicand / MTHI-MTLO source).
- req_b  input  32  rt value (divisor / multiplier).
- req_ready  output  1  block can accept an operation this cycle.
- flush  input  1  exception/ERET flush; cancels in-flight operation.
- rd_hilo  input  1  decode holds MFHI or MFLO this cycle.
- rd_stall  output  1  decode must hold; combinational.
- busy  output  1  operation in flight.
- hi  output  32  architectural HI.
- lo  output  32  architectural LO.

Behaviour:
Clock and reset:
- Single clock clk.
- reset is synchronous and active-high, sampled on the clk rising edge.
- Reset values: hi=0, lo=0, state=IDLE, counters=0, busy=0, req_ready=1, rd_stall=0.
- Reset mid-operation aborts the operation; HI/LO go to 0.

States:
- IDLE, MUL, DIV, DFIX.
- req_ready = (state==IDLE).
- busy = (state!=IDLE).
- rd_stall = rd_hilo & busy.
- Accept = req_valid & req_ready & ~flush.

IDLE:
- MTHI: hi <= req_a at the accept edge; lo unchanged; stays IDLE. MTLO is symmetric.
- MULT/MULTU: latch operands; cnt <= MUL_LAT-1; go to MUL. If MUL_LAT==1, write directly at the accept edge and stay IDLE.
- DIV/DIVU with req_b==0: HI/LO unchanged; stays IDLE. This is a 0-cycle no-op.
- DIV/DIVU with req_b!=0: latch magnitudes (signed ops take |a| and |b|), the sign of the quotient (a31^b31) and the sign of the remainder (a31); cnt <= 0; go to DIV.

MUL:
- cnt decrements each cycle.
- At cnt==0: {hi,lo} <= 64-bit product (signed for MULT, unsigned for MULTU); go to IDLE.
- Total latency: the HI/LO update lands at accept edge + MUL_LAT.

DIV:
- One restoring step per cycle: shift the remainder/quotient pair left 1 bit, trial-subtract the divisor, and keep the result if it is non-negative.
- After DIV_ITER steps, go to DFIX.

DFIX:
- Apply signs: negate the quotient if qsign is set, negate the remainder if rsign is set.
- lo <= quotient, hi <= remainder; go to IDLE.
- Total latency: HI/LO update at accept edge + 33.
- 0x80000000 / 0xFFFFFFFF (signed) gives lo=0x80000000, hi=0 (two's-complement wrap).

flush:
- Any state goes to IDLE at the next edge.
- HI/LO are not written by the cancelled operation.
- flush beats a same-cycle completion write and a same-cycle accept.
- An MTHI/MTLO offered with flush=1 is dropped.

Other rules:
- While busy, req_valid is ignored (req_ready=0); the requester must hold the request.
- hi/lo outputs are registers; no bypass. MFHI in the cycle after a completion edge sees the new value, and rd_stall is already 0 in that cycle.

Test Plan:
- Reset, then MTHI a=0x12345678 followed next cycle by MTLO a=0x9ABCDEF0 -> hi=0x12345678, lo=0x9ABCDEF0, busy never 1.
- MULT a=0xFFFFFFFE (-2), b=0x00000003 with rd_hilo=1 held -> rd_stall=1 for exactly 3 cycles; hi=0xFFFFFFFF, lo=0xFFFFFFFA at accept+3. MULTU with the same operands -> hi=0x00000002, lo=0xFFFFFFFA.
- DIV a=0xFFFFFFF9 (-7), b=2 -> busy for 33 cycles, lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU a=100, b=7 -> lo=14, hi=2. DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
- DIVU with b=0 after MTHI 5 / MTLO 6 -> hi=5, lo=6 unchanged, busy stays 0.
- DIV accepted, flush at cycle 10 -> IDLE next edge, HI/LO hold prior values, req_ready=1. Also assert flush exactly on the DFIX cycle -> no write.
- Reset asserted during a MULT at cycle 1 -> hi=lo=0, busy=0 next edge. req_valid held during DIV -> second op accepted only on the cycle after completion.
